// File: rtl/controlador_suma_bcd_serial.sv
// Digit-serial packed-BCD adder: one shared 4-bit BCD digit adder is stepped
// across the operands from the least-significant digit upward, carry held between digits.

module sumador_BCD_4bits (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Ac_in,
  output logic [3:0] Z_salida,
  output logic       Acarreo_BCD
);

  // Decimal correction: binary sums of 10 or more are pushed past 15 by adding 6.
  function automatic logic [4:0] corregir_bcd(input logic [4:0] s);
    return (s >= 5'd10) ? s + 5'd6 : s;
  endfunction

  logic [4:0] suma_bin;
  logic [4:0] suma_bcd;

  assign suma_bin = {1'b0, A} + {1'b0, B} + {4'b0000, Ac_in};
  assign suma_bcd = corregir_bcd(suma_bin);
  assign Z_salida    = suma_bcd[3:0];
  assign Acarreo_BCD = suma_bcd[4];

endmodule

module controlador_suma_bcd_serial #(
  parameter int N_DIGITOS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   inicio,
  input  logic [4*N_DIGITOS-1:0] A,
  input  logic [4*N_DIGITOS-1:0] B,
  input  logic                   Ac_in,
  output logic [4*N_DIGITOS-1:0] Z,
  output logic                   Acarreo_final,
  output logic                   ocupado,
  output logic                   listo,
  output logic                   error_bcd
);

  localparam int W  = 4 * N_DIGITOS;
  localparam int CW = $clog2(N_DIGITOS);
  localparam logic [CW-1:0] ULTIMO = CW'(N_DIGITOS - 1);

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    SUMA   = 2'd1,
    FIN    = 2'd2
  } estado_t;

  function automatic logic hay_digito_invalido(input logic [W-1:0] v);
    logic r;
    r = 1'b0;
    for (int i = 0; i < N_DIGITOS; i++) begin
      if (v[4*i +: 4] > 4'd9) r = 1'b1;
    end
    return r;
  endfunction

  estado_t       estado, estado_sig;
  logic [CW-1:0] contador;
  logic          acarreo_r;
  logic [W-1:0]  regA, regB;
  logic [W-1:0]  z_r;
  logic          acarreo_final_r;
  logic          error_r;

  logic          operando_invalido;
  logic [3:0]    digito_a, digito_b;
  logic [3:0]    z_salida;
  logic          acarreo_bcd;

  assign operando_invalido = hay_digito_invalido(A) | hay_digito_invalido(B);

  always_comb begin
    digito_a = 4'd0;
    digito_b = 4'd0;
    for (int i = 0; i < N_DIGITOS; i++) begin
      if (contador == CW'(i)) begin
        digito_a = regA[4*i +: 4];
        digito_b = regB[4*i +: 4];
      end
    end
  end

  sumador_BCD_4bits u_sumador (
    .A          (digito_a),
    .B          (digito_b),
    .Ac_in      (acarreo_r),
    .Z_salida   (z_salida),
    .Acarreo_BCD(acarreo_bcd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= REPOSO;
    else        estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    case (estado)
      REPOSO: if (inicio) estado_sig = operando_invalido ? FIN : SUMA;
      SUMA:   if (contador == ULTIMO) estado_sig = FIN;
      FIN:    estado_sig = REPOSO;
      default: estado_sig = REPOSO;
    endcase
  end

  always_comb begin
    ocupado = (estado == SUMA);
    listo   = (estado == FIN);
  end

  // Operand capture: pure data, only meaningful once an operation is accepted.
  always_ff @(posedge clk) begin
    if (estado == REPOSO && inicio) begin
      regA <= A;
      regB <= B;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contador        <= '0;
      acarreo_r       <= 1'b0;
      z_r             <= '0;
      acarreo_final_r <= 1'b0;
      error_r         <= 1'b0;
    end else begin
      case (estado)
        REPOSO: begin
          if (inicio) begin
            contador        <= '0;
            acarreo_r       <= Ac_in;
            z_r             <= '0;
            acarreo_final_r <= 1'b0;
            error_r         <= operando_invalido;
          end
        end
        SUMA: begin
          for (int i = 0; i < N_DIGITOS; i++) begin
            if (contador == CW'(i)) z_r[4*i +: 4] <= z_salida;
          end
          acarreo_r <= acarreo_bcd;
          contador  <= contador + 1'b1;
          if (contador == ULTIMO) acarreo_final_r <= acarreo_bcd;
        end
        default: ;
      endcase
    end
  end

  assign Z             = z_r;
  assign Acarreo_final = acarreo_final_r;
  assign error_bcd     = error_r;

endmodule
